maxpool2x2_stream: RTL and testbench

//  Streaming 2x2 stride-2 signed max-pool for the U-Net encoder path, directly downstream of convolutor3x3.

---
 rtl/unet_pkg.sv | 14 +
 rtl/maxpool2x2_stream_pool_line_buffer.sv | 38 +++
 rtl/maxpool2x2_stream.sv | 191 +++++++++++++++++++
 tb/tb_maxpool2x2_stream.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/unet_pkg.sv
// Shared constants and state encoding for the U-Net encoder streaming blocks.
package unet_pkg;

    localparam int DEF_DATA_W    = 32;
    localparam int DEF_MAX_WIDTH = 128;
    localparam int DEF_DIM_W     = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } pool_state_e;

endpackage

// File: rtl/maxpool2x2_stream_pool_line_buffer.sv
// Half-width line buffer holding even-row pair maxima: one write port, one registered read port.
module pool_line_buffer #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 64,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [AW-1:0]     rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [DATA_W-1:0] rd_data_r;

    // Storage array; never reset because every read follows a same-frame write.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    // Registered read port; holds its value between reads so input gaps are tolerated.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_r <= {DATA_W{1'b0}};
        end else if (rd_en) begin
            rd_data_r <= mem_r[rd_addr];
        end
    end

    assign rd_data = rd_data_r;

endmodule

// File: rtl/maxpool2x2_stream.sv
// Streaming 2x2 stride-2 signed max-pool over raster-order samples, one pooled value per window.
module maxpool2x2_stream
    import unet_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int MAX_WIDTH = DEF_MAX_WIDTH,
    parameter int DIM_W     = DEF_DIM_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic [DIM_W-1:0]  width,
    input  logic [DIM_W-1:0]  height,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              frame_done,
    output logic              err_cfg
);

    localparam int LB_DEPTH = MAX_WIDTH / 2;
    localparam int LB_AW    = $clog2(LB_DEPTH);

    function automatic logic [DATA_W-1:0] smax(input logic signed [DATA_W-1:0] a,
                                               input logic signed [DATA_W-1:0] b);
        return (a > b) ? a : b;
    endfunction

    pool_state_e       state_r, state_n_s;
    logic [DIM_W-1:0]  col_r, col_n_s, row_r, row_n_s;
    logic [DIM_W-1:0]  width_r, width_n_s, height_r, height_n_s;
    logic [DIM_W-1:0]  eff_w_s, eff_h_s, last_col_s, last_row_s;
    logic [DATA_W-1:0] hold_r, hold_n_s, out_data_r, out_data_n_s;
    logic [DATA_W-1:0] pair_max_s, rd_data_s;
    logic              out_valid_r, out_valid_n_s, out_last_r, out_last_n_s;
    logic              frame_done_r, frame_done_n_s, err_cfg_r, err_cfg_n_s;
    logic              cfg_ok_s, proc_s, wr_en_s, rd_en_s;
    logic [LB_AW-1:0]  lb_addr_s;

    // Geometry comes from the live inputs at frame start, from the latched copy while running.
    always_comb begin
        if (state_r == ST_RUN) begin
            eff_w_s = width_r;
            eff_h_s = height_r;
        end else begin
            eff_w_s = width;
            eff_h_s = height;
        end
    end

    assign cfg_ok_s   = (width >= DIM_W'(2)) && (height >= DIM_W'(2)) &&
                        ({1'b0, width} <= (DIM_W + 1)'(MAX_WIDTH));
    // Last pooled column/row: odd trailing column or row never produces output.
    assign last_col_s = {eff_w_s[DIM_W-1:1], 1'b0} - DIM_W'(1);
    assign last_row_s = {eff_h_s[DIM_W-1:1], 1'b0} - DIM_W'(1);
    assign pair_max_s = smax(hold_r, in_data);
    assign lb_addr_s  = LB_AW'(col_r >> 1);

    pool_line_buffer #(
        .DATA_W (DATA_W),
        .DEPTH  (LB_DEPTH)
    ) u_line_buffer (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en_s),
        .wr_addr (lb_addr_s),
        .wr_data (pair_max_s),
        .rd_en   (rd_en_s),
        .rd_addr (lb_addr_s),
        .rd_data (rd_data_s)
    );

    // Next-state: frame FSM, raster counters, pooling datapath and output pulses.
    always_comb begin
        state_n_s      = state_r;
        col_n_s        = col_r;
        row_n_s        = row_r;
        width_n_s      = width_r;
        height_n_s     = height_r;
        hold_n_s       = hold_r;
        out_data_n_s   = out_data_r;
        out_valid_n_s  = 1'b0;
        out_last_n_s   = 1'b0;
        frame_done_n_s = 1'b0;
        err_cfg_n_s    = err_cfg_r;
        proc_s         = 1'b0;
        wr_en_s        = 1'b0;
        rd_en_s        = 1'b0;

        if (clear) begin
            state_n_s   = ST_IDLE;
            col_n_s     = {DIM_W{1'b0}};
            row_n_s     = {DIM_W{1'b0}};
            err_cfg_n_s = 1'b0;
        end else begin
            if (state_r == ST_DONE) begin
                state_n_s = ST_IDLE;
            end else begin
                state_n_s = state_r;
            end
            if (in_valid) begin
                case (state_r)
                    ST_IDLE, ST_DONE: begin
                        width_n_s  = width;
                        height_n_s = height;
                        if (cfg_ok_s) begin
                            proc_s    = 1'b1;
                            state_n_s = ST_RUN;
                        end else begin
                            err_cfg_n_s = 1'b1;
                        end
                    end
                    ST_RUN: begin
                        proc_s = 1'b1;
                    end
                    default: begin
                        state_n_s = ST_IDLE;
                    end
                endcase
            end else begin
                proc_s = 1'b0;
            end
        end

        if (proc_s) begin
            if (!col_r[0]) begin
                hold_n_s = in_data;
                rd_en_s  = row_r[0];
            end else if (!row_r[0]) begin
                wr_en_s = 1'b1;
            end else begin
                out_valid_n_s = 1'b1;
                out_data_n_s  = smax(rd_data_s, pair_max_s);
                out_last_n_s  = (row_r == last_row_s) && (col_r == last_col_s);
            end

            if (col_r == eff_w_s - DIM_W'(1)) begin
                col_n_s = {DIM_W{1'b0}};
                if (row_r == eff_h_s - DIM_W'(1)) begin
                    row_n_s        = {DIM_W{1'b0}};
                    state_n_s      = ST_DONE;
                    frame_done_n_s = 1'b1;
                end else begin
                    row_n_s = row_r + DIM_W'(1);
                end
            end else begin
                col_n_s = col_r + DIM_W'(1);
            end
        end else begin
            hold_n_s = hold_r;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            col_r        <= {DIM_W{1'b0}};
            row_r        <= {DIM_W{1'b0}};
            width_r      <= {DIM_W{1'b0}};
            height_r     <= {DIM_W{1'b0}};
            hold_r       <= {DATA_W{1'b0}};
            out_data_r   <= {DATA_W{1'b0}};
            out_valid_r  <= 1'b0;
            out_last_r   <= 1'b0;
            frame_done_r <= 1'b0;
            err_cfg_r    <= 1'b0;
        end else begin
            state_r      <= state_n_s;
            col_r        <= col_n_s;
            row_r        <= row_n_s;
            width_r      <= width_n_s;
            height_r     <= height_n_s;
            hold_r       <= hold_n_s;
            out_data_r   <= out_data_n_s;
            out_valid_r  <= out_valid_n_s;
            out_last_r   <= out_last_n_s;
            frame_done_r <= frame_done_n_s;
            err_cfg_r    <= err_cfg_n_s;
        end
    end

    assign out_valid  = out_valid_r;
    assign out_data   = out_data_r;
    assign out_last   = out_last_r;
    assign frame_done = frame_done_r;
    assign err_cfg    = err_cfg_r;

endmodule

// File: tb/tb_maxpool2x2_stream.sv
// Directed self-checking bench for maxpool2x2_stream with hand-computed pooled results.
module tb_maxpool2x2_stream;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clear = 1'b0;
    logic [7:0]  width = 8'd0;
    logic [7:0]  height = 8'd0;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = 32'd0;
    logic        out_valid, out_last, frame_done, err_cfg;
    logic [31:0] out_data;

    int n_vec = 0;
    int n_err = 0;
    int pix [64];
    int expq [$];

    maxpool2x2_stream dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (clear),
        .width      (width),
        .height     (height),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_last   (out_last),
        .frame_done (frame_done),
        .err_cfg    (err_cfg)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    // Apply one cycle of input; outputs are then sampled 1 time unit after the edge.
    task automatic drive(input logic v, input logic [31:0] d);
        in_valid = v;
        in_data  = d;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic load_test1();
        int t [16] = '{544, 22, 0, 3699, 14, 0, 100, 0, 1, 2, 0, 0, 36, 76, 0, 38};
        for (int i = 0; i < 16; i++) pix[i] = t[i];
        expq = '{544, 3699, 76, 38};
    endtask

    task automatic run_frame(input int w, input int h, input int gapmax);
        int g;
        int e;
        logic exp_v;
        width  = 8'(w);
        height = 8'(h);
        for (int r = 0; r < h; r++) begin
            for (int c = 0; c < w; c++) begin
                g = (gapmax > 0) ? int'($urandom_range(0, gapmax)) : 0;
                for (int k = 0; k < g; k++) begin
                    drive(1'b0, $urandom);
                    chk("gap_out_valid", {31'd0, out_valid}, 32'd0);
                    chk("gap_frame_done", {31'd0, frame_done}, 32'd0);
                end
                drive(1'b1, pix[r*w+c]);
                if (r == 0 && c == 0) begin
                    width  = 8'd0;
                    height = 8'd1;
                end
                exp_v = (r % 2 == 1) && (c % 2 == 1) && (c < (w/2)*2) && (r < (h/2)*2);
                chk("out_valid", {31'd0, out_valid}, {31'd0, exp_v});
                if (exp_v) begin
                    e = (expq.size() > 0) ? expq.pop_front() : 0;
                    chk("out_data", out_data, e);
                    chk("out_last", {31'd0, out_last},
                        {31'd0, (r == (h/2)*2-1) && (c == (w/2)*2-1)});
                end
                chk("frame_done", {31'd0, frame_done}, {31'd0, (r == h-1) && (c == w-1)});
            end
        end
        chk("out_count_left", expq.size(), 32'd0);
    endtask

    initial begin
        // Reset state, with activity on the inputs.
        width = 8'd4;
        height = 8'd4;
        drive(1'b1, 32'd123);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_out_last", {31'd0, out_last}, 32'd0);
        chk("rst_frame_done", {31'd0, frame_done}, 32'd0);
        chk("rst_err_cfg", {31'd0, err_cfg}, 32'd0);
        rst_n = 1'b1;
        drive(1'b0, 32'd0);

        // 1: 4x4 continuous, then 2: 2x2 negative started straight out of DONE.
        load_test1();
        run_frame(4, 4, 0);
        pix[0] = -5; pix[1] = -3; pix[2] = -9; pix[3] = -7;
        expq = '{-3};
        run_frame(2, 2, 0);
        drive(1'b0, 32'd0);
        chk("idle_frame_done", {31'd0, frame_done}, 32'd0);

        // 3: test 1 with random input gaps.
        load_test1();
        run_frame(4, 4, 3);

        // 4: 5x3, odd width and odd height.
        for (int i = 0; i < 15; i++) pix[i] = i + 1;
        expq = '{7, 9};
        run_frame(5, 3, 0);
        drive(1'b0, 32'd0);

        // 5: partial frame aborted by clear (clear beats a simultaneous sample).
        width = 8'd4;
        height = 8'd4;
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 32'(9001 + i));
        end
        chk("part_out_valid", {31'd0, out_valid}, 32'd1);
        chk("part_out_data", out_data, 32'd9006);
        clear = 1'b1;
        drive(1'b1, 32'd99999);
        clear = 1'b0;
        chk("clr_out_valid", {31'd0, out_valid}, 32'd0);
        chk("clr_frame_done", {31'd0, frame_done}, 32'd0);
        load_test1();
        run_frame(4, 4, 0);
        drive(1'b0, 32'd0);

        // 6: illegal configurations and recovery.
        width = 8'd1;
        height = 8'd4;
        drive(1'b1, 32'd77);
        chk("w1_out_valid", {31'd0, out_valid}, 32'd0);
        chk("w1_err_cfg", {31'd0, err_cfg}, 32'd1);
        drive(1'b0, 32'd0);
        chk("w1_err_sticky", {31'd0, err_cfg}, 32'd1);
        clear = 1'b1;
        drive(1'b0, 32'd0);
        clear = 1'b0;
        chk("clr_err_cfg", {31'd0, err_cfg}, 32'd0);
        width = 8'd200;
        height = 8'd2;
        drive(1'b1, 32'd5);
        chk("wbig_err_cfg", {31'd0, err_cfg}, 32'd1);
        width = 8'd4;
        height = 8'd1;
        clear = 1'b1;
        drive(1'b0, 32'd0);
        clear = 1'b0;
        drive(1'b1, 32'd5);
        chk("h1_err_cfg", {31'd0, err_cfg}, 32'd1);
        clear = 1'b1;
        drive(1'b0, 32'd0);
        clear = 1'b0;
        chk("clr2_err_cfg", {31'd0, err_cfg}, 32'd0);
        pix[0] = -5; pix[1] = -3; pix[2] = -9; pix[3] = -7;
        expq = '{-3};
        run_frame(2, 2, 0);
        drive(1'b0, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
